// File: rtl/inst_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit_pkg
//   Shared constants and types for the instruction-fetch front end.
//   RESET_PC_DEF : PC loaded on reset (MIPS text base)
//   NOP_INST     : value presented on inst_out while the queue holds nothing
//   ROM_AW_DEF   : default ROM byte-address width
//   INST_W       : instruction width
//   CNT_W_DEF    : default width of the fetch performance counter
//   fetch_entry_t: one {pc, inst} queue slot
// ---------------------------------------------------------------------------
package inst_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0000;
    localparam int          ROM_AW_DEF   = 12;
    localparam int          INST_W       = 32;
    localparam int          CNT_W_DEF    = 16;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Instructions are word aligned; low two bits of a target are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Two-entry {pc, inst} FIFO between the ROM port and decode.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     flush       : drop every entry (redirect); wins over push/pop
//     push        : write push_entry at tail (caller guarantees not full,
//                   or full with a simultaneous pop)
//     pop         : advance head (caller guarantees not empty)
//     push_entry  : {pc, inst} to write
//     head        : entry at the head (meaningful only while count != 0)
//     count       : number of valid entries, 0..2
// ---------------------------------------------------------------------------
module fetch_queue
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t entries [2];
    logic         rd_ptr;
    logic         wr_ptr;

    // Slots are reset so that the head reads {RESET_PC, NOP} straight out
    // of reset, before anything has been fetched.
    always_ff @(posedge clk) begin
        if (rst) begin
            entries[0] <= '{pc: RESET_PC, inst: NOP_INST};
            entries[1] <= '{pc: RESET_PC, inst: NOP_INST};
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_entry;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (!push && pop) begin
                count <= count - 2'd1;
            end
        end
    end

    assign head = entries[rd_ptr];

endmodule

// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
//   Instruction-fetch front end. Owns the PC, addresses a combinational
//   instruction ROM, buffers fetched words in a 2-entry queue and hands them
//   to decode over valid/ready. Execute redirects flush all stale fetches.
//   Ports:
//     clk, rst       : clock, synchronous active-high reset
//     rom_addr       : ROM byte address = low ROM_AW bits of fetch PC
//     rom_data       : ROM word for rom_addr (same cycle)
//     inst_valid     : queue head holds an instruction
//     inst_ready     : decode takes the head this cycle
//     inst_out       : instruction at head
//     inst_pc        : PC of instruction at head
//     redirect_valid : execute requests a PC change
//     redirect_pc    : redirect target
//     align_err      : sticky, a redirect target had nonzero bits [1:0]
//     fetch_count    : words written into the queue, saturating
// ---------------------------------------------------------------------------
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          ROM_AW   = ROM_AW_DEF,
    parameter int          CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [31:0]       inst_pc,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              align_err,
    output logic [CNT_W-1:0]  fetch_count
);

    logic [31:0]  fetch_pc;
    logic [1:0]   q_count;
    logic         push;
    logic         pop;
    fetch_entry_t q_head;
    fetch_entry_t q_wdata;

    assign rom_addr   = fetch_pc[ROM_AW-1:0];
    assign inst_valid = (q_count != 2'd0);
    assign pop        = inst_valid && inst_ready;
    // A full queue can still accept a word when decode drains one this cycle,
    // which is what gives one instruction per cycle with no bubbles.
    assign push       = !rst && !redirect_valid && ((q_count != 2'd2) || pop);
    assign q_wdata    = '{pc: fetch_pc, inst: rom_data};

    fetch_queue #(
        .RESET_PC (RESET_PC)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .pop        (pop),
        .push_entry (q_wdata),
        .head       (q_head),
        .count      (q_count)
    );

    assign inst_out = q_head.inst;
    assign inst_pc  = q_head.pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            align_err   <= 1'b0;
            fetch_count <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= word_align(redirect_pc);
            if (redirect_pc[1:0] != 2'b00) begin
                align_err <= 1'b1;
            end
        end else if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
            if (fetch_count != {CNT_W{1'b1}}) begin
                fetch_count <= fetch_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench: directed scenarios plus randomized traffic, every cycle compared
// against a queue-based behavioural model of the fetch front end.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] rom_addr;
    logic [31:0] rom_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        align_err;
    logic [15:0] fetch_count;

    always #5 clk = ~clk;

    assign rom_data = 32'hC0DE_0000 | {20'h0, rom_addr};

    inst_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .align_err      (align_err),
        .fetch_count    (fetch_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ment_t;

    ment_t       mq[$];
    logic [31:0] m_pc;
    logic        m_align;
    logic [15:0] m_fc;
    logic        m_reset_head;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_check();
        chk("valid", {31'h0, inst_valid}, {31'h0, mq.size() != 0});
        if (mq.size() != 0) begin
            chk("head_pc", inst_pc, mq[0].pc);
            chk("head_inst", inst_out, mq[0].inst);
        end else if (m_reset_head) begin
            chk("rst_pc", inst_pc, 32'h0040_0000);
            chk("rst_inst", inst_out, 32'h0);
        end
        chk("rom_addr", {20'h0, rom_addr}, {20'h0, m_pc[11:0]});
        chk("align_err", {31'h0, align_err}, {31'h0, m_align});
        chk("fetch_count", {16'h0, fetch_count}, {16'h0, m_fc});
    endtask

    // Drive one cycle of inputs, advance the model, clock, then compare.
    task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
        bit do_pop;
        bit do_push;
        rst            = r;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (r) begin
            mq.delete();
            m_pc         = 32'h0040_0000;
            m_align      = 1'b0;
            m_fc         = 16'h0;
            m_reset_head = 1'b1;
        end else begin
            do_pop = (mq.size() != 0) && rdy;
            if (rv) begin
                mq.delete();
                m_pc = rpc & 32'hFFFF_FFFC;
                if (rpc[1:0] != 2'b00) m_align = 1'b1;
            end else begin
                do_push = (mq.size() < 2) || do_pop;
                if (do_pop) void'(mq.pop_front());
                if (do_push) begin
                    mq.push_back('{pc: m_pc, inst: 32'hC0DE_0000 | {20'h0, m_pc[11:0]}});
                    m_pc = m_pc + 32'd4;
                    if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
                    m_reset_head = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        model_check();
    endtask

    initial begin
        logic [31:0] rpc;
        rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        m_pc = 32'h0040_0000; m_align = 1'b0; m_fc = 16'h0; m_reset_head = 1'b1;

        // 1: reset, then streaming with ready=1
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("t1_rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("t1_rst_pc", inst_pc, 32'h0040_0000);
        chk("t1_rst_inst", inst_out, 32'h0);
        step(0, 1, 0, 0);
        chk("t1_pc0", inst_pc, 32'h0040_0000);
        chk("t1_inst0", inst_out, 32'hC0DE_0000);
        step(0, 1, 0, 0);
        chk("t1_pc1", inst_pc, 32'h0040_0004);
        chk("t1_inst1", inst_out, 32'hC0DE_0004);
        step(0, 1, 0, 0);
        chk("t1_pc2", inst_pc, 32'h0040_0008);
        chk("t1_inst2", inst_out, 32'hC0DE_0008);

        // 2: stall five cycles after reset, then drain without gaps
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        chk("t2_rom_addr", {20'h0, rom_addr}, 32'h008);
        chk("t2_fcount", {16'h0, fetch_count}, 32'd2);
        chk("t2_head0", inst_pc, 32'h0040_0000);
        step(0, 1, 0, 0);
        chk("t2_head1", inst_pc, 32'h0040_0004);
        step(0, 1, 0, 0);
        chk("t2_head2", inst_pc, 32'h0040_0008);

        // 3: redirect with a full queue
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h0040_0098);
        chk("t3_bubble", {31'h0, inst_valid}, 32'h0);
        step(0, 0, 0, 0);
        chk("t3_pc", inst_pc, 32'h0040_0098);
        chk("t3_inst", inst_out, 32'hC0DE_0098);

        // 4: misaligned redirect sets the sticky flag
        step(0, 1, 1, 32'h0040_0042);
        chk("t4_align", {31'h0, align_err}, 32'h1);
        step(0, 1, 0, 0);
        chk("t4_pc", inst_pc, 32'h0040_0040);
        for (int i = 0; i < 6; i++) step(0, 1'($urandom_range(0, 1)), 0, 0);
        chk("t4_sticky", {31'h0, align_err}, 32'h1);

        // 5: redirect + pop same cycle, then reset in the middle of a stall
        step(0, 0, 0, 0);
        step(0, 1, 1, 32'h0040_0100);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("t5_valid", {31'h0, inst_valid}, 32'h0);
        chk("t5_inst", inst_out, 32'h0);
        chk("t5_pc", inst_pc, 32'h0040_0000);
        chk("t5_align", {31'h0, align_err}, 32'h0);
        chk("t5_fcount", {16'h0, fetch_count}, 32'h0);
        step(0, 0, 0, 0);
        chk("t5_restart", inst_pc, 32'h0040_0000);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rpc = 32'h0040_0000 | (32'($urandom_range(0, 1023)) << 2);
            if ($urandom_range(0, 7) == 0) rpc = rpc | 32'($urandom_range(1, 3));
            step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 7) == 0), rpc);
        end

        // 6: counter saturation and PC wrap
        step(1, 0, 0, 0);
        for (int i = 0; i < 32'h10000; i++) step(0, 1, 0, 0);
        chk("t6_sat", {16'h0, fetch_count}, 32'hFFFF);
        step(0, 1, 0, 0);
        chk("t6_sat_hold", {16'h0, fetch_count}, 32'hFFFF);
        step(0, 1, 1, 32'hFFFF_FFFC);
        step(0, 1, 0, 0);
        chk("t6_top", inst_pc, 32'hFFFF_FFFC);
        step(0, 1, 0, 0);
        chk("t6_wrap", inst_pc, 32'h0000_0000);
        chk("t6_wrap_inst", inst_out, 32'hC0DE_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
